// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes, funcs,
// mux selects and the Moore strobe decode used by the FSM.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEMADR    = 4'd3,
        MEMRD     = 4'd4,
        MEMWB     = 4'd5,
        MEMWR     = 4'd6,
        EXEC      = 4'd7,
        RTYPE_WB  = 4'd8,
        ADDI_EXEC = 4'd9,
        ADDI_WB   = 4'd10,
        BRANCH    = 4'd11,
        JUMP      = 4'd12,
        ILLEGAL   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALUSEL_AND = 3'b000;
    localparam logic [2:0] ALUSEL_OR  = 3'b001;
    localparam logic [2:0] ALUSEL_ADD = 3'b010;
    localparam logic [2:0] ALUSEL_SUB = 3'b110;
    localparam logic [2:0] ALUSEL_SLT = 3'b111;

    localparam logic [1:0] ALUSRCB_REG = 2'd0;
    localparam logic [1:0] ALUSRCB_ONE = 2'd1;
    localparam logic [1:0] ALUSRCB_IMM = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_sel;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    // State-only strobes; BRANCH PCEn and EXEC ALUSel are completed in the top.
    function automatic ctrl_t moore_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = ALUSRCB_ONE;
                c.alu_sel   = ALUSEL_ADD;
                c.pc_source = PCSRC_ALU;
                c.pc_en     = 1'b1;
            end
            DECODE: begin
                c.alu_src_b = ALUSRCB_IMM;
                c.alu_sel   = ALUSEL_ADD;
            end
            MEMADR, ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUSRCB_IMM;
                c.alu_sel   = ALUSEL_ADD;
            end
            MEMRD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.instr_done = 1'b1;
            end
            MEMWR: begin
                c.iord       = 1'b1;
                c.mem_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUSRCB_REG;
            end
            RTYPE_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b1;
                c.instr_done = 1'b1;
            end
            ADDI_WB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = ALUSRCB_REG;
                c.alu_sel    = ALUSEL_SUB;
                c.pc_source  = PCSRC_ALUOUT;
                c.instr_done = 1'b1;
            end
            JUMP: begin
                c.pc_source  = PCSRC_JUMP;
                c.pc_en      = 1'b1;
                c.instr_done = 1'b1;
            end
            ILLEGAL: c.illegal = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// R-type func field to ALU operation select, with a flag marking supported funcs.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] func_i,
    output logic [2:0] alu_sel_o,
    output logic       func_valid_o
);

    always_comb begin
        alu_sel_o    = ALUSEL_AND;
        func_valid_o = 1'b1;
        case (func_i)
            FN_ADD:  alu_sel_o = ALUSEL_ADD;
            FN_SUB:  alu_sel_o = ALUSEL_SUB;
            FN_AND:  alu_sel_o = ALUSEL_AND;
            FN_OR:   alu_sel_o = ALUSEL_OR;
            FN_SLT:  alu_sel_o = ALUSEL_SLT;
            default: func_valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing
// with run gate, sticky illegal-instruction halt and per-instruction retire pulse.
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUSel,
    output logic       illegal,
    output logic       instr_done,
    output logic [3:0] state_dbg
);

    state_t     state_q, state_d;
    ctrl_t      ctrl_q;
    logic [2:0] func_sel;
    logic       func_valid;
    logic       branch_take;

    alu_decoder u_alu_dec (
        .func_i       (func),
        .alu_sel_o    (func_sel),
        .func_valid_o (func_valid)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (run) state_d = FETCH;
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:   state_d = MEMADR;
                    OP_RTYPE:       state_d = func_valid ? EXEC : ILLEGAL;
                    OP_ADDI:        state_d = ADDI_EXEC;
                    OP_BEQ, OP_BNE: state_d = BRANCH;
                    OP_J:           state_d = JUMP;
                    default:        state_d = ILLEGAL;
                endcase
            end
            MEMADR:    state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:     state_d = MEMWB;
            EXEC:      state_d = RTYPE_WB;
            ADDI_EXEC: state_d = ADDI_WB;
            MEMWB, MEMWR, RTYPE_WB, ADDI_WB, BRANCH, JUMP: state_d = IDLE;
            ILLEGAL:   state_d = ILLEGAL;
            default:   state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= moore_ctrl(state_d);
        end
    end

    assign branch_take = (opcode == OP_BNE) ? ~zero : zero;

    assign PCEn       = ctrl_q.pc_en | ((state_q == BRANCH) & branch_take);
    assign ALUSel     = (state_q == EXEC) ? func_sel : ctrl_q.alu_sel;
    assign IorD       = ctrl_q.iord;
    assign MemRead    = ctrl_q.mem_read;
    assign MemWrite   = ctrl_q.mem_write;
    assign MemtoReg   = ctrl_q.mem_to_reg;
    assign IRWrite    = ctrl_q.ir_write;
    assign RegWrite   = ctrl_q.reg_write;
    assign RegDst     = ctrl_q.reg_dst;
    assign ALUSrcA    = ctrl_q.alu_src_a;
    assign ALUSrcB    = ctrl_q.alu_src_b;
    assign PCSource   = ctrl_q.pc_source;
    assign illegal    = ctrl_q.illegal;
    assign instr_done = ctrl_q.instr_done;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed and random instruction streams
// compared cycle by cycle against an instruction-level reference model.
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst, run, zero;
    logic [5:0] opcode, func;
    logic       PCEn, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUSel;
    logic       illegal, instr_done;
    logic [3:0] state_dbg;

    int   total = 0;
    int   bad   = 0;
    logic prev_pcen = 1'b0;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .func(func), .zero(zero),
        .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUSel(ALUSel),
        .illegal(illegal), .instr_done(instr_done), .state_dbg(state_dbg)
    );

    function automatic logic [21:0] obs_vec();
        return {PCEn, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst,
                ALUSrcA, ALUSrcB, PCSource, ALUSel, illegal, instr_done, state_dbg};
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2A:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit fn_ok(input logic [5:0] fn);
        return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A;
    endfunction

    // Expected strobe vector for one step of an instruction, straight from the strobe list.
    function automatic logic [21:0] model(input state_t s, input logic [5:0] op,
                                          input logic [5:0] fn, input logic z);
        logic pcen = 0, iord = 0, mr = 0, mw = 0, m2r = 0, irw = 0, rw = 0, rd = 0;
        logic sa = 0, ill = 0, done = 0;
        logic [1:0] sb = 0, ps = 0;
        logic [2:0] al = 0;
        case (s)
            FETCH:     begin mr = 1; irw = 1; sb = 2'd1; al = 3'b010; pcen = 1; end
            DECODE:    begin sb = 2'd2; al = 3'b010; end
            MEMADR:    begin sa = 1; sb = 2'd2; al = 3'b010; end
            MEMRD:     begin iord = 1; mr = 1; end
            MEMWB:     begin rw = 1; m2r = 1; done = 1; end
            MEMWR:     begin iord = 1; mw = 1; done = 1; end
            EXEC:      begin sa = 1; al = alu_of(fn); end
            RTYPE_WB:  begin rw = 1; rd = 1; done = 1; end
            ADDI_EXEC: begin sa = 1; sb = 2'd2; al = 3'b010; end
            ADDI_WB:   begin rw = 1; done = 1; end
            BRANCH:    begin sa = 1; al = 3'b110; ps = 2'd1; done = 1;
                             pcen = (op == 6'h05) ? ~z : z; end
            JUMP:      begin ps = 2'd2; pcen = 1; done = 1; end
            ILLEGAL:   ill = 1;
            default:   ;
        endcase
        return {pcen, iord, mr, mw, m2r, irw, rw, rd, sa, sb, ps, al, ill, done, s};
    endfunction

    task automatic check(input string tag, input logic [21:0] exp);
        logic [21:0] o;
        o = obs_vec();
        total++;
        assert (o === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, exp);
        end
        total++;
        assert (!(prev_pcen && PCEn)) else begin
            bad++;
            $error("FAIL %s pcen_back_to_back: observed=1 expected=0", tag);
        end
        prev_pcen = PCEn;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode);
        state_t seq[$];
        int     exp_lat, done_at, gap;
        case (op)
            6'h23: begin seq = {FETCH, DECODE, MEMADR, MEMRD, MEMWB}; exp_lat = 5; end
            6'h2B: begin seq = {FETCH, DECODE, MEMADR, MEMWR}; exp_lat = 4; end
            6'h08: begin seq = {FETCH, DECODE, ADDI_EXEC, ADDI_WB}; exp_lat = 4; end
            6'h04, 6'h05: begin seq = {FETCH, DECODE, BRANCH}; exp_lat = 3; end
            6'h02: begin seq = {FETCH, DECODE, JUMP}; exp_lat = 3; end
            6'h00: begin
                if (fn_ok(fn)) begin seq = {FETCH, DECODE, EXEC, RTYPE_WB}; exp_lat = 4; end
                else begin seq = {FETCH, DECODE, ILLEGAL}; exp_lat = 0; end
            end
            default: begin seq = {FETCH, DECODE, ILLEGAL}; exp_lat = 0; end
        endcase
        opcode  = op;
        func    = fn;
        run     = 1'b1;
        done_at = 0;
        for (int i = 0; i < seq.size(); i++) begin
            step();
            run  = 1'($urandom_range(0, 1));
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            #1;
            check($sformatf("op%h_fn%h_cyc%0d", op, fn, i + 1), model(seq[i], op, fn, zero));
            if (instr_done && done_at == 0) done_at = i + 1;
        end
        if (seq[seq.size() - 1] == ILLEGAL) begin
            for (int k = 0; k < 20; k++) begin
                step();
                run  = ~run;
                zero = 1'($urandom_range(0, 1));
                #1;
                check($sformatf("illegal_hold_%0d", k), model(ILLEGAL, op, fn, zero));
            end
            rst = 1'b1;
            run = 1'b0;
            step();
            #1;
            check("illegal_cleared_by_rst", model(IDLE, op, fn, zero));
            rst = 1'b0;
        end else begin
            total++;
            assert (done_at === exp_lat) else begin
                bad++;
                $error("FAIL latency_op%h: observed=%0d expected=%0d", op, done_at, exp_lat);
            end
            step();
            run = 1'b0;
            #1;
            check($sformatf("op%h_back_to_idle", op), model(IDLE, op, fn, zero));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                step();
                #1;
                check("idle_park", model(IDLE, op, fn, zero));
            end
        end
    endtask

    logic [5:0] ops [7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02};
    logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    initial begin
        rst    = 1'b1;
        run    = 1'b0;
        zero   = 1'b0;
        opcode = 6'h00;
        func   = 6'h00;
        step();
        step();
        #1;
        check("reset_state", model(IDLE, 6'h00, 6'h00, 1'b0));
        rst = 1'b0;

        // Abandon an lw in MEMRD with a one-cycle reset, then restart cleanly.
        opcode = 6'h23;
        run    = 1'b1;
        step(); #1; check("lw_abort_fetch",  model(FETCH,  6'h23, 6'h00, zero));
        step(); #1; check("lw_abort_decode", model(DECODE, 6'h23, 6'h00, zero));
        step(); #1; check("lw_abort_memadr", model(MEMADR, 6'h23, 6'h00, zero));
        step(); #1; check("lw_abort_memrd",  model(MEMRD,  6'h23, 6'h00, zero));
        rst = 1'b1;
        run = 1'b0;
        step(); #1; check("reset_in_memrd", model(IDLE, 6'h23, 6'h00, zero));
        rst = 1'b0;
        run_instr(6'h23, 6'h00, 2);

        run_instr(6'h00, 6'h22, 2);
        run_instr(6'h00, 6'h2A, 2);
        run_instr(6'h00, 6'h20, 2);
        run_instr(6'h00, 6'h24, 2);
        run_instr(6'h00, 6'h25, 2);
        run_instr(6'h04, 6'h00, 1);
        run_instr(6'h04, 6'h00, 0);
        run_instr(6'h05, 6'h00, 0);
        run_instr(6'h05, 6'h00, 1);
        run_instr(6'h02, 6'h00, 2);
        run_instr(6'h2B, 6'h00, 2);
        run_instr(6'h08, 6'h11, 2);

        for (int n = 0; n < 40; n++) begin
            logic [5:0] op_r, fn_r;
            op_r = ops[$urandom_range(0, 6)];
            fn_r = (op_r == 6'h00) ? fns[$urandom_range(0, 4)] : 6'($urandom_range(0, 63));
            run_instr(op_r, fn_r, 2);
        end

        run_instr(6'h3F, 6'h20, 2);
        run_instr(6'h00, 6'h00, 2);
        run_instr(6'h2B, 6'h00, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
